bcd_sequential: RTL and testbench

BCD_SEQUENTIAL -- requirements
Module: bcd_sequential

---
 rtl/bcd_sequential_if.sv | 24 ++
 rtl/bcd_sequential.sv | 147 ++++++++++++++
 tb/tb_bcd_sequential.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bcd_sequential_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives start/bin; the slave (converter) returns status and result.
interface bcd_sequential_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, blank
    );
endinterface

// File: rtl/bcd_sequential.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero mask on blank is enabled by defining BCD_SEQ_BLANK_EN.
module bcd_sequential #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_sequential_if.slave  bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  shift_r;
    logic [SW-1:0]     scratch_r;
    logic              ovf_r;
    logic [CW-1:0]     step_r;
    logic              busy_r;
    logic              done_r;
    logic [SW-1:0]     bcd_r;
    logic              overflow_r;
    logic [SW-1:0]     adj_s;
    logic [SW-1:0]     next_scratch_s;
    logic              next_ovf_s;

    // Add 3 to every digit that would reach 10 or more after doubling.
    function automatic logic [SW-1:0] dabble_adjust(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble step; the bit leaving the top digit is worth 10^DIGITS.
    always_comb begin
        adj_s          = dabble_adjust(scratch_r);
        next_scratch_s = {adj_s[SW-2:0], shift_r[WIDTH-1]};
        next_ovf_s     = ovf_r | adj_s[SW-1];
    end

`ifdef BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_r;

    // Digit i (i >= 1) is blank when it and every digit above it are zero.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [SW-1:0] s);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = {DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (s[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    // Leading-zero mask register, updated only when a conversion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_r <= {DIGITS{1'b0}};
        end else if (state_r == ST_CONVERT && step_r == CW'(WIDTH - 1)) begin
            blank_r <= blank_mask(next_scratch_s);
        end else begin
            blank_r <= blank_r;
        end
    end

    assign bus.blank = blank_r;
`else
    assign bus.blank = {DIGITS{1'b0}};
`endif

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= {WIDTH{1'b0}};
            scratch_r  <= {SW{1'b0}};
            ovf_r      <= 1'b0;
            step_r     <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {SW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shift_r   <= bus.bin;
                        scratch_r <= {SW{1'b0}};
                        ovf_r     <= 1'b0;
                        step_r    <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_CONVERT;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    scratch_r <= next_scratch_s;
                    shift_r   <= {shift_r[WIDTH-2:0], 1'b0};
                    ovf_r     <= next_ovf_s;
                    step_r    <= step_r + CW'(1);
                    if (step_r == CW'(WIDTH - 1)) begin
                        bcd_r      <= next_scratch_s;
                        overflow_r <= next_ovf_s;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        done_r     <= 1'b0;
                        state_r    <= ST_CONVERT;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcd      = bcd_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_bcd_sequential.sv
// Directed self-checking bench for bcd_sequential in three configurations:
// 8-bit/3-digit, 8-bit/2-digit and 16-bit/5-digit.
module tb_bcd_sequential;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n;
    int   cnt;

`ifdef BCD_SEQ_BLANK_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    bcd_sequential_if #(.WIDTH(8),  .DIGITS(3)) ifa ();
    bcd_sequential_if #(.WIDTH(8),  .DIGITS(2)) ifb ();
    bcd_sequential_if #(.WIDTH(16), .DIGITS(5)) ifc ();

    bcd_sequential #(.WIDTH(8),  .DIGITS(3)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bcd_sequential #(.WIDTH(8),  .DIGITS(2)) ub (.clk(clk), .rst_n(rst_n), .bus(ifb));
    bcd_sequential #(.WIDTH(16), .DIGITS(5)) uc (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is high across exactly one rising edge.
    task automatic pulse(input int sel, input logic [31:0] b);
        case (sel)
            0:       begin ifa.start = 1'b1; ifa.bin = b[7:0];  end
            1:       begin ifb.start = 1'b1; ifb.bin = b[7:0];  end
            default: begin ifc.start = 1'b1; ifc.bin = b[15:0]; end
        endcase
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
    endtask

    // Counts negedges until done is seen; 40 means it never came.
    task automatic wait_done(input int sel, output int cycles);
        logic d;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            case (sel)
                0:       d = ifa.done;
                1:       d = ifb.done;
                default: d = ifc.done;
            endcase
            if (d === 1'b1) break;
        end
    endtask

    logic [7:0]  tbl_bin   [3] = '{8'd0, 8'd7, 8'd42};
    logic [11:0] tbl_bcd   [3] = '{12'h000, 12'h007, 12'h042};
    logic [2:0]  tbl_blank [3] = '{3'b110, 3'b110, 3'b100};

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        ifa.start = 1'b0; ifa.bin = 8'd0;
        ifb.start = 1'b0; ifb.bin = 8'd0;
        ifc.start = 1'b0; ifc.bin = 16'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy",  64'(ifa.busy),     64'd0);
        check_eq("rst_done",  64'(ifa.done),     64'd0);
        check_eq("rst_bcd",   64'(ifa.bcd),      64'd0);
        check_eq("rst_ovf",   64'(ifa.overflow), 64'd0);
        check_eq("rst_blank", 64'(ifa.blank),    64'd0);
        rst_n = 1'b1;

        // 255: start accepted on the first edge after reset release
        pulse(0, 32'd255);
        wait_done(0, n);
        check_eq("a255_lat",   64'(n),            64'd8);
        check_eq("a255_bcd",   64'(ifa.bcd),      64'h255);
        check_eq("a255_ovf",   64'(ifa.overflow), 64'd0);
        check_eq("a255_blank", 64'(ifa.blank),    64'd0);
        check_eq("a255_busy",  64'(ifa.busy),     64'd1);
        @(negedge clk);
        check_eq("a255_pulse", 64'(ifa.done),     64'd0);
        check_eq("a255_idle",  64'(ifa.busy),     64'd0);
        check_eq("a255_hold",  64'(ifa.bcd),      64'h255);

        for (int k = 0; k < 3; k++) begin
            pulse(0, 32'(tbl_bin[k]));
            wait_done(0, n);
            check_eq("ablk_lat",   64'(n),         64'd8);
            check_eq("ablk_bcd",   64'(ifa.bcd),   64'(tbl_bcd[k]));
            check_eq("ablk_blank", 64'(ifa.blank), BE ? 64'(tbl_blank[k]) : 64'd0);
            @(negedge clk);
        end

        // Two-digit instance: 200 wraps to 00 with overflow, 99 fits
        pulse(1, 32'd200);
        wait_done(1, n);
        check_eq("b200_lat",   64'(n),            64'd8);
        check_eq("b200_bcd",   64'(ifb.bcd),      64'h00);
        check_eq("b200_ovf",   64'(ifb.overflow), 64'd1);
        check_eq("b200_blank", 64'(ifb.blank),    BE ? 64'd2 : 64'd0);
        @(negedge clk);
        pulse(1, 32'd99);
        wait_done(1, n);
        check_eq("b99_bcd",    64'(ifb.bcd),      64'h99);
        check_eq("b99_ovf",    64'(ifb.overflow), 64'd0);
        check_eq("b99_blank",  64'(ifb.blank),    64'd0);
        @(negedge clk);

        // 16-bit: a second start with a new bin during busy must be ignored
        pulse(2, 32'd65535);
        repeat (3) @(negedge clk);
        pulse(2, 32'd1);
        wait_done(2, n);
        check_eq("c_lat",  64'(n + 4),         64'd16);
        check_eq("c_bcd",  64'(ifc.bcd),       64'h65535);
        check_eq("c_ovf",  64'(ifc.overflow),  64'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.done === 1'b1) cnt++;
        end
        check_eq("c_ignored", 64'(cnt), 64'd0);

        // Back-to-back: second start in the idle cycle right after DONE
        pulse(0, 32'd10);
        wait_done(0, n);
        check_eq("bb1_lat", 64'(n),       64'd8);
        check_eq("bb1_bcd", 64'(ifa.bcd), 64'h010);
        @(negedge clk);
        pulse(0, 32'd11);
        wait_done(0, n);
        // done-low cycles between the two pulses: the idle cycle, start edge, 7 steps
        check_eq("bb_gap",  64'(n + 1),   64'd9);
        check_eq("bb2_bcd", 64'(ifa.bcd), 64'h011);
        @(negedge clk);

        // Reset during step 4 aborts the conversion
        pulse(0, 32'd200);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 64'(ifa.busy), 64'd0);
        check_eq("rst_mid_bcd",  64'(ifa.bcd),  64'd0);
        check_eq("rst_mid_done", 64'(ifa.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (ifa.done === 1'b1) cnt++;
        end
        check_eq("rst_no_done", 64'(cnt),     64'd0);
        check_eq("rst_no_upd",  64'(ifa.bcd), 64'd0);
        pulse(0, 32'd128);
        wait_done(0, n);
        check_eq("a128_lat",   64'(n),            64'd8);
        check_eq("a128_bcd",   64'(ifa.bcd),      64'h128);
        check_eq("a128_ovf",   64'(ifa.overflow), 64'd0);
        check_eq("a128_blank", 64'(ifa.blank),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
